usb_rx_stream: RTL

USB_RX_STREAM -- requirements
Module: usb_rx_stream

---
 rtl/usb_rx_pkg.sv | 31 +++
 rtl/usb_rx_fifo.sv | 56 +++++
 rtl/usb_rx_stream.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive stream decoder.
package usb_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP,
        ST_ERR_WAIT
    } rx_state_e;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_SYNC     = 3'd1,
        ERR_STUFF    = 3'd2,
        ERR_ALIGN    = 3'd3,
        ERR_EOP      = 3'd4,
        ERR_EMPTY    = 3'd5,
        ERR_OVERFLOW = 3'd6
    } rx_err_e;

    localparam logic [7:0] SYNC_PATTERN = 8'h80;
    localparam int         STUFF_LIMIT  = 6;

    typedef struct packed {
        logic       err;
        logic       last;
        logic [7:0] data;
    } rx_entry_t;

endpackage

// File: rtl/usb_rx_fifo.sv
// Receive FIFO of {err,last,data} entries; a dropped closing entry marks the tail instead.
module usb_rx_fifo
    import usb_rx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  rx_entry_t wdata,
    input  logic      pop,
    output rx_entry_t rdata,
    output logic      empty,
    output logic      overflow
);

    localparam int AW = $clog2(DEPTH);

    rx_entry_t  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] tail_ptr;
    logic        full;
    logic        do_push;
    logic        do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;
    assign tail_ptr = wr_ptr - 1'b1;
    assign rdata    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end else if (overflow && wdata.last) begin
            // Packet end was lost: close the packet on the newest stored byte.
            mem[tail_ptr[AW-1:0]].err  <= 1'b1;
            mem[tail_ptr[AW-1:0]].last <= 1'b1;
        end
    end

endmodule

// File: rtl/usb_rx_stream.sv
// USB full-speed receive path: line sync, bit recovery, NRZI/unstuffing, packet FSM, byte FIFO.
module usb_rx_stream
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_plus_in,
    input  logic       d_minus_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_last,
    output logic       rx_err,
    input  logic       rx_ready,
    output logic [2:0] error_code,
    output logic       error_pulse,
    output logic       busy
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  SAMPLE_AT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  WRAP_AT   = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     STUFF_N   = 3'(STUFF_LIMIT);

    // Line synchroniser, idles at J
    logic dp_s1, dp_s2, dm_s1, dm_s2, dp_last;
    logic [CW-1:0] phase_cnt;
    logic sample, edge_det, se0, line_j, line_k, dbit;

    always_ff @(posedge clk) begin
        if (rst) begin
            dp_s1     <= 1'b1;
            dp_s2     <= 1'b1;
            dm_s1     <= 1'b0;
            dm_s2     <= 1'b0;
            dp_last   <= 1'b1;
            phase_cnt <= '0;
        end else begin
            dp_s1   <= d_plus_in;
            dp_s2   <= dp_s1;
            dm_s1   <= d_minus_in;
            dm_s2   <= dm_s1;
            dp_last <= dp_s2;
            if (edge_det || phase_cnt == WRAP_AT) phase_cnt <= '0;
            else                                  phase_cnt <= phase_cnt + 1'b1;
        end
    end

    assign edge_det = (dp_s2 != dp_last);
    assign sample   = (phase_cnt == SAMPLE_AT) && !edge_det;
    assign se0      = !dp_s2 && !dm_s2;
    assign line_j   =  dp_s2 && !dm_s2;
    assign line_k   = !dp_s2 &&  dm_s2;

    // Packet FSM and datapath
    rx_state_e  state, state_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic [7:0] shreg, shreg_n, new_byte;
    logic [7:0] hold, hold_n;
    logic       hold_vld, hold_vld_n;
    logic [2:0] ones, ones_n;
    logic       prev_dp, prev_n;
    logic       eop2, eop2_n;
    logic       se0_seen, se0_seen_n;
    logic [2:0] j_cnt, j_cnt_n;
    logic       push, fsm_err, sync_start;
    rx_err_e    fsm_code;
    rx_entry_t  push_entry, head;
    logic       fifo_empty, fifo_ovf, pop;
    rx_err_e    err_code_q;

    assign dbit     = (dp_s2 == prev_dp);
    assign new_byte = {dbit, shreg[7:1]};

    always_comb begin
        state_n    = state;
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        hold_n     = hold;
        hold_vld_n = hold_vld;
        ones_n     = ones;
        prev_n     = prev_dp;
        eop2_n     = eop2;
        se0_seen_n = se0_seen;
        j_cnt_n    = j_cnt;
        push       = 1'b0;
        push_entry = '0;
        fsm_err    = 1'b0;
        fsm_code   = ERR_NONE;
        sync_start = 1'b0;

        if (sample) begin
            if (!se0) prev_n = dp_s2;
            unique case (state)
                ST_IDLE: begin
                    if (line_k) begin
                        // First K is SYNC bit 0, decoded against the reset J.
                        state_n    = ST_SYNC;
                        sync_start = 1'b1;
                        shreg_n    = {dbit, 7'd0};
                        bit_idx_n  = 3'd1;
                        ones_n     = '0;
                        hold_vld_n = 1'b0;
                    end else begin
                        prev_n = 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (se0) begin
                        fsm_err  = 1'b1;
                        fsm_code = ERR_SYNC;
                    end else begin
                        shreg_n   = new_byte;
                        ones_n    = dbit ? ones + 1'b1 : '0;
                        bit_idx_n = bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            if (new_byte == SYNC_PATTERN) begin
                                state_n = ST_DATA;
                            end else begin
                                fsm_err  = 1'b1;
                                fsm_code = ERR_SYNC;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (se0) begin
                        if (bit_idx == 3'd0) begin
                            state_n = ST_EOP;
                            eop2_n  = 1'b0;
                        end else begin
                            fsm_err  = 1'b1;
                            fsm_code = ERR_ALIGN;
                        end
                    end else if (ones == STUFF_N) begin
                        if (dbit) begin
                            fsm_err  = 1'b1;
                            fsm_code = ERR_STUFF;
                        end else begin
                            ones_n = '0;
                        end
                    end else begin
                        ones_n    = dbit ? ones + 1'b1 : '0;
                        shreg_n   = new_byte;
                        bit_idx_n = bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            // One byte of delay so the packet's last byte can carry last=1.
                            hold_n     = new_byte;
                            hold_vld_n = 1'b1;
                            if (hold_vld) begin
                                push       = 1'b1;
                                push_entry = '{err: 1'b0, last: 1'b0, data: hold};
                            end
                        end
                    end
                end
                ST_EOP: begin
                    if (!eop2) begin
                        if (se0) begin
                            eop2_n = 1'b1;
                        end else begin
                            fsm_err  = 1'b1;
                            fsm_code = ERR_EOP;
                        end
                    end else if (line_j) begin
                        if (hold_vld) begin
                            push       = 1'b1;
                            push_entry = '{err: 1'b0, last: 1'b1, data: hold};
                            hold_vld_n = 1'b0;
                            state_n    = ST_IDLE;
                            prev_n     = 1'b1;
                        end else begin
                            fsm_err  = 1'b1;
                            fsm_code = ERR_EMPTY;
                        end
                    end else begin
                        fsm_err  = 1'b1;
                        fsm_code = ERR_EOP;
                    end
                end
                ST_ERR_WAIT: begin
                    if (se0) begin
                        se0_seen_n = 1'b1;
                        j_cnt_n    = '0;
                    end else if (line_j) begin
                        if (se0_seen || j_cnt == 3'd7) begin
                            state_n = ST_IDLE;
                            prev_n  = 1'b1;
                        end else begin
                            j_cnt_n = j_cnt + 1'b1;
                        end
                    end else begin
                        j_cnt_n = '0;
                    end
                end
                default: state_n = ST_IDLE;
            endcase

            if (fsm_err) begin
                push       = 1'b1;
                push_entry = '{err: 1'b1, last: 1'b1, data: hold_vld ? hold : 8'h00};
                hold_vld_n = 1'b0;
                state_n    = ST_ERR_WAIT;
                se0_seen_n = se0;
                j_cnt_n    = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            bit_idx  <= '0;
            shreg    <= '0;
            hold     <= '0;
            hold_vld <= 1'b0;
            ones     <= '0;
            prev_dp  <= 1'b1;
            eop2     <= 1'b0;
            se0_seen <= 1'b0;
            j_cnt    <= '0;
        end else begin
            state    <= state_n;
            bit_idx  <= bit_idx_n;
            shreg    <= shreg_n;
            hold     <= hold_n;
            hold_vld <= hold_vld_n;
            ones     <= ones_n;
            prev_dp  <= prev_n;
            eop2     <= eop2_n;
            se0_seen <= se0_seen_n;
            j_cnt    <= j_cnt_n;
        end
    end

    // Overflow wins over a same-cycle FSM error.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_code_q  <= ERR_NONE;
            error_pulse <= 1'b0;
        end else begin
            error_pulse <= fsm_err | fifo_ovf;
            if (fifo_ovf)        err_code_q <= ERR_OVERFLOW;
            else if (fsm_err)    err_code_q <= fsm_code;
            else if (sync_start) err_code_q <= ERR_NONE;
        end
    end

    usb_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .wdata    (push_entry),
        .pop      (pop),
        .rdata    (head),
        .empty    (fifo_empty),
        .overflow (fifo_ovf)
    );

    assign pop        = rx_valid && rx_ready;
    assign rx_valid   = !fifo_empty;
    assign rx_data    = head.data;
    assign rx_last    = head.last;
    assign rx_err     = head.err;
    assign error_code = err_code_q;
    assign busy       = (state != ST_IDLE);

endmodule
